// File: rtl/ceespu_pkg.sv
// Shared definitions for the ceespu core: opcodes, instruction field positions
// and fixed reset/interrupt addresses.
package ceespu_pkg;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RA_LSB  = 16;
  localparam int unsigned RB_LSB  = 11;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] INT_BASE = 16'h0100;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SHL  = 4'h5;
  localparam logic [3:0] ALU_SHR  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  localparam logic [5:0] OP_ALU_LAST  = 6'h09;
  localparam logic [5:0] OP_IMM_FIRST = 6'h10;
  localparam logic [5:0] OP_IMM_LAST  = 6'h19;
  localparam logic [5:0] OP_LUI   = 6'h1A;
  localparam logic [5:0] OP_LW    = 6'h20;
  localparam logic [5:0] OP_LBU   = 6'h21;
  localparam logic [5:0] OP_SW    = 6'h22;
  localparam logic [5:0] OP_SB    = 6'h23;
  localparam logic [5:0] OP_BEQ   = 6'h28;
  localparam logic [5:0] OP_BNE   = 6'h29;
  localparam logic [5:0] OP_BLT   = 6'h2A;
  localparam logic [5:0] OP_BGE   = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h2C;
  localparam logic [5:0] OP_JAL   = 6'h2D;
  localparam logic [5:0] OP_RETI  = 6'h2E;
  localparam logic [5:0] OP_SETIE = 6'h2F;

endpackage

// File: rtl/ceespu_alu.sv
// Combinational 32-bit ALU covering the register/immediate ALU operations.
module ceespu_alu
  import ceespu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SHL:  y = a << b[4:0];
      ALU_SHR:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/ceespu_core.sv
// Two-stage ceespu core: single-cycle fetch/execute plus a load writeback stage
// with forwarding, vectored interrupt and data-memory stall.
module ceespu_core
  import ceespu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] O_imemAddress,
  output logic        O_imemEnable,
  output logic        O_imemReset,
  input  logic [31:0] I_imemData,
  output logic [15:0] O_dmemAddress,
  output logic [31:0] O_dmemWData,
  output logic        O_dmemE,
  output logic [3:0]  O_dmemWe,
  input  logic [31:0] I_dmemData,
  input  logic        I_dmemBusy,
  input  logic        I_int_req,
  input  logic [2:0]  I_int_vector,
  output logic        O_int_ack
);

  logic [15:0] pc, epc, pcNext;
  logic        ie, ieNext;
  logic [31:0] rf [32];

  logic        loadPend, loadByte, isLoad;
  logic [4:0]  loadRd;
  logic [1:0]  loadLane;
  logic [31:0] loadData;

  logic [5:0]  op;
  logic [4:0]  rd, ra, rb;
  logic [15:0] imm, ea;
  logic [31:0] simm, zimm, raVal, rbVal, rdVal;
  logic [3:0]  aluOp;
  logic [31:0] aluB, aluY, wbData;
  logic        wbEn, stall, intTake, exec;

  assign op   = I_imemData[OPC_LSB +: 6];
  assign rd   = I_imemData[RD_LSB +: 5];
  assign ra   = I_imemData[RA_LSB +: 5];
  assign rb   = I_imemData[RB_LSB +: 5];
  assign imm  = I_imemData[15:0];
  assign simm = {{16{imm[15]}}, imm};
  assign zimm = {16'b0, imm};

  always_comb begin
    loadData = I_dmemData;
    if (loadByte) begin
      case (loadLane)
        2'd0:    loadData = {24'b0, I_dmemData[7:0]};
        2'd1:    loadData = {24'b0, I_dmemData[15:8]};
        2'd2:    loadData = {24'b0, I_dmemData[23:16]};
        default: loadData = {24'b0, I_dmemData[31:24]};
      endcase
    end
  end

  // The pending load is not yet in rf, so its data is forwarded straight from the bus.
  assign raVal = (ra == 5'd0) ? '0 : (loadPend && loadRd == ra) ? loadData : rf[ra];
  assign rbVal = (rb == 5'd0) ? '0 : (loadPend && loadRd == rb) ? loadData : rf[rb];
  assign rdVal = (rd == 5'd0) ? '0 : (loadPend && loadRd == rd) ? loadData : rf[rd];

  assign ea      = raVal[15:0] + imm;
  assign stall   = I_dmemBusy;
  assign intTake = I_int_req && ie && !stall && !rst;
  assign exec    = !rst && !intTake;

  ceespu_alu u_alu (.op(aluOp), .a(raVal), .b(aluB), .y(aluY));

  always_comb begin
    aluOp         = op[3:0];
    aluB          = rbVal;
    wbEn          = 1'b0;
    wbData        = aluY;
    pcNext        = pc + 16'd4;
    ieNext        = ie;
    isLoad        = 1'b0;
    O_dmemE       = 1'b0;
    O_dmemWe      = '0;
    O_dmemAddress = '0;
    O_dmemWData   = '0;
    if (exec) begin
      if (op <= OP_ALU_LAST) begin
        wbEn = 1'b1;
      end else if (op >= OP_IMM_FIRST && op <= OP_IMM_LAST) begin
        wbEn = 1'b1;
        aluB = (op[3:0] == ALU_AND || op[3:0] == ALU_OR || op[3:0] == ALU_XOR) ? zimm : simm;
      end else begin
        case (op)
          OP_LUI: begin wbEn = 1'b1; wbData = {imm, 16'b0}; end
          OP_LW, OP_LBU: begin
            isLoad        = 1'b1;
            O_dmemE       = 1'b1;
            O_dmemAddress = ea;
          end
          OP_SW: begin
            O_dmemE       = 1'b1;
            O_dmemAddress = ea;
            O_dmemWe      = '1;
            O_dmemWData   = rdVal;
          end
          OP_SB: begin
            O_dmemE       = 1'b1;
            O_dmemAddress = ea;
            O_dmemWe      = 4'b0001 << ea[1:0];
            O_dmemWData   = {4{rdVal[7:0]}};
          end
          OP_BEQ: if (rdVal == raVal) pcNext = pc + {imm[13:0], 2'b00};
          OP_BNE: if (rdVal != raVal) pcNext = pc + {imm[13:0], 2'b00};
          OP_BLT: if ($signed(rdVal) < $signed(raVal)) pcNext = pc + {imm[13:0], 2'b00};
          OP_BGE: if ($signed(rdVal) >= $signed(raVal)) pcNext = pc + {imm[13:0], 2'b00};
          OP_J:   pcNext = {imm[15:2], 2'b00};
          OP_JAL: begin
            wbEn   = 1'b1;
            wbData = {16'b0, pc + 16'd4};
            pcNext = {ea[15:2], 2'b00};
          end
          OP_RETI:  begin pcNext = epc; ieNext = 1'b1; end
          OP_SETIE: ieNext = imm[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      epc      <= '0;
      ie       <= 1'b0;
      loadPend <= 1'b0;
      loadByte <= 1'b0;
      loadRd   <= '0;
      loadLane <= '0;
    end else if (!stall) begin
      if (intTake) begin
        epc <= pc;
        ie  <= 1'b0;
        pc  <= INT_BASE + {11'b0, I_int_vector, 2'b00};
      end else begin
        pc <= pcNext;
        ie <= ieNext;
      end
      loadPend <= isLoad;
      loadByte <= (op == OP_LBU);
      loadRd   <= rd;
      loadLane <= ea[1:0];
    end
  end

  // Older load writeback first so a same-cycle ALU write to that register wins.
  always_ff @(posedge clk) begin
    if (!rst && !stall) begin
      if (loadPend && loadRd != 5'd0) rf[loadRd] <= loadData;
      if (wbEn && rd != 5'd0) rf[rd] <= wbData;
    end
  end

  assign O_imemAddress = pc;
  assign O_imemEnable  = !rst && !I_dmemBusy;
  assign O_imemReset   = rst;
  assign O_int_ack     = intTake;

endmodule

// File: tb/tb_ceespu_core.sv
// Directed self-checking bench for ceespu_core with a bench-driven instruction port.
module tb_ceespu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] O_imemAddress;
  logic        O_imemEnable, O_imemReset;
  logic [31:0] I_imemData;
  logic [15:0] O_dmemAddress;
  logic [31:0] O_dmemWData;
  logic        O_dmemE;
  logic [3:0]  O_dmemWe;
  logic [31:0] I_dmemData;
  logic        I_dmemBusy, I_int_req;
  logic [2:0]  I_int_vector;
  logic        O_int_ack;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  ceespu_core dut (
    .clk(clk), .rst(rst),
    .O_imemAddress(O_imemAddress), .O_imemEnable(O_imemEnable), .O_imemReset(O_imemReset),
    .I_imemData(I_imemData),
    .O_dmemAddress(O_dmemAddress), .O_dmemWData(O_dmemWData), .O_dmemE(O_dmemE),
    .O_dmemWe(O_dmemWe), .I_dmemData(I_dmemData), .I_dmemBusy(I_dmemBusy),
    .I_int_req(I_int_req), .I_int_vector(I_int_vector), .O_int_ack(O_int_ack)
  );

  function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rd, ra, rb);
    return {op, rd, ra, rb, 11'b0};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rd, ra,
                                       input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle and present an instruction there.
  task automatic cyc(input logic [31:0] ins);
    @(negedge clk);
    I_imemData = ins;
    #1;
  endtask

  initial begin
    rst = 1'b1; I_imemData = '0; I_dmemData = '0; I_dmemBusy = 1'b0;
    I_int_req = 1'b0; I_int_vector = '0;

    cyc(32'h0);
    chk("rst_imemReset", {31'b0, O_imemReset}, 32'd1);
    chk("rst_imemEnable", {31'b0, O_imemEnable}, 32'd0);
    chk("rst_imemAddr", {16'b0, O_imemAddress}, 32'h0);
    chk("rst_dmemE", {31'b0, O_dmemE}, 32'd0);
    chk("rst_dmemWe", {28'b0, O_dmemWe}, 32'd0);
    chk("rst_intAck", {31'b0, O_int_ack}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_addr0", {16'b0, O_imemAddress}, 32'h0);
    chk("rel_enable", {31'b0, O_imemEnable}, 32'd1);
    cyc(32'h0); chk("nop_addr4", {16'b0, O_imemAddress}, 32'h4);
    cyc(32'h0); chk("nop_addr8", {16'b0, O_imemAddress}, 32'h8);

    // ALU forwarding into a store
    cyc(encI(6'h10, 5'd1, 5'd0, 16'd5));
    cyc(encI(6'h10, 5'd2, 5'd1, 16'd3));
    cyc(encI(6'h22, 5'd2, 5'd0, 16'h0010));
    chk("sw_wdata", O_dmemWData, 32'd8);
    chk("sw_addr", {16'b0, O_dmemAddress}, 32'h10);
    chk("sw_we", {28'b0, O_dmemWe}, 32'hF);
    chk("sw_e", {31'b0, O_dmemE}, 32'd1);

    // Load-use forwarding, then the committed value
    cyc(encI(6'h20, 5'd3, 5'd0, 16'h0000));
    I_dmemData = 32'd2;
    #1;
    chk("lw_e", {31'b0, O_dmemE}, 32'd1);
    chk("lw_we", {28'b0, O_dmemWe}, 32'h0);
    cyc(encR(6'h00, 5'd4, 5'd3, 5'd3));
    cyc(encI(6'h22, 5'd4, 5'd0, 16'h0004));
    chk("loaduse_wdata", O_dmemWData, 32'd4);
    chk("loaduse_addr", {16'b0, O_dmemAddress}, 32'h4);
    I_dmemData = 32'd7;
    cyc(encI(6'h22, 5'd3, 5'd0, 16'h0008));
    chk("lw_commit", O_dmemWData, 32'd2);

    // Younger ALU write beats the pending load to the same register
    I_dmemData = 32'd9;
    cyc(encI(6'h20, 5'd5, 5'd0, 16'h0000));
    cyc(encI(6'h10, 5'd5, 5'd0, 16'd1));
    cyc(encI(6'h22, 5'd5, 5'd0, 16'h0000));
    chk("younger_wins", O_dmemWData, 32'd1);

    // LBU lane select with forwarding
    I_dmemData = 32'hAABBCCDD;
    cyc(encI(6'h21, 5'd6, 5'd0, 16'h0002));
    cyc(encI(6'h22, 5'd6, 5'd0, 16'h0000));
    chk("lbu_lane2", O_dmemWData, 32'h000000BB);

    // Branches: BNE taken backwards, BEQ not taken
    cyc(encI(6'h29, 5'd0, 5'd1, 16'hFFFE));
    chk("bne_pc", {16'b0, O_imemAddress}, 32'd60);
    cyc(encI(6'h28, 5'd0, 5'd1, 16'hFFFE));
    chk("bne_target", {16'b0, O_imemAddress}, 32'd52);
    cyc(encI(6'h1A, 5'd7, 5'd0, 16'h8000));
    chk("beq_fallthru", {16'b0, O_imemAddress}, 32'd56);

    // SRA and signed compare
    cyc(encI(6'h17, 5'd7, 5'd7, 16'd4));
    cyc(encI(6'h22, 5'd7, 5'd0, 16'h0000));
    chk("srai", O_dmemWData, 32'hF8000000);
    cyc(encR(6'h08, 5'd8, 5'd7, 5'd1));
    cyc(encI(6'h22, 5'd8, 5'd0, 16'h0000));
    chk("slt", O_dmemWData, 32'd1);

    // Interrupt entry; the interrupted instruction must not execute
    cyc(encI(6'h2F, 5'd0, 5'd0, 16'd1));
    cyc(encI(6'h10, 5'd1, 5'd0, 16'd99));
    chk("int_pc", {16'b0, O_imemAddress}, 32'd80);
    I_int_req = 1'b1; I_int_vector = 3'd3;
    #1;
    chk("int_ack", {31'b0, O_int_ack}, 32'd1);
    chk("int_no_dmem", {31'b0, O_dmemE}, 32'd0);
    cyc(encI(6'h22, 5'd1, 5'd0, 16'h0000));
    chk("int_vec_addr", {16'b0, O_imemAddress}, 32'h010C);
    chk("int_ack_once", {31'b0, O_int_ack}, 32'd0);
    chk("int_squash", O_dmemWData, 32'd5);
    cyc(encI(6'h2E, 5'd0, 5'd0, 16'h0000));
    I_int_req = 1'b0;
    cyc(32'h0);
    chk("reti_pc", {16'b0, O_imemAddress}, 32'd80);
    I_int_req = 1'b1; I_int_vector = 3'd1;
    #1;
    chk("reti_ie", {31'b0, O_int_ack}, 32'd1);

    // Stall during a byte store at ea=0x21
    cyc(encI(6'h23, 5'd1, 5'd0, 16'h0021));
    I_int_req = 1'b0;
    I_dmemBusy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc", {16'b0, O_imemAddress}, 32'h0104);
      chk("stall_we", {28'b0, O_dmemWe}, 32'h2);
      chk("stall_addr", {16'b0, O_dmemAddress}, 32'h21);
      chk("stall_en", {31'b0, O_imemEnable}, 32'd0);
      if (i < 2) cyc(encI(6'h23, 5'd1, 5'd0, 16'h0021));
    end
    cyc(encI(6'h23, 5'd1, 5'd0, 16'h0021));
    I_dmemBusy = 1'b0;
    #1;
    chk("release_pc", {16'b0, O_imemAddress}, 32'h0104);
    chk("release_wdata", O_dmemWData, 32'h05050505);
    cyc(encI(6'h2C, 5'd0, 5'd0, 16'h0203));
    chk("advance_once", {16'b0, O_imemAddress}, 32'h0108);

    // J and JAL
    cyc(encI(6'h2D, 5'd10, 5'd0, 16'h0040));
    chk("j_target", {16'b0, O_imemAddress}, 32'h0200);
    cyc(encI(6'h22, 5'd10, 5'd0, 16'h0000));
    chk("jal_target", {16'b0, O_imemAddress}, 32'h0040);
    chk("jal_link", O_dmemWData, 32'h0204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
